// File: rtl/csi2_rx_pkg.sv
// csi2_rx_pkg: shared encodings for the CSI-2
// byte-clock receive path.
package csi2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_ALIGNED = 2'd2,
    ST_ERROR   = 2'd3
  } align_state_e;

  localparam logic [7:0] HS_SYNC_BYTE = 8'hB8;
  localparam int         MAX_LANE     = 4;

endpackage

// File: rtl/lane_deskew_tap.sv
// lane_deskew_tap: per-lane byte delay line, sync
// detect on the newest tap, and skew tap mux.
module lane_deskew_tap
  import csi2_rx_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [7:0] SYNC  = HS_SYNC_BYTE,
  parameter int         SW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [7:0]    bd_i,
  input  logic [SW-1:0] sel_i,
  output logic          det_o,
  output logic [7:0]    tap_o
);

  logic [7:0] tap_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++)
        tap_q[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < DEPTH; k++)
        tap_q[k] <= '0;
    end else begin
      tap_q[0] <= bd_i;
      for (int k = 1; k < DEPTH; k++)
        tap_q[k] <= tap_q[k-1];
    end
  end

  assign det_o = (tap_q[0] == SYNC);
  assign tap_o = tap_q[sel_i];

endmodule

// File: rtl/lane_aligner.sv
// lane_aligner: hunts the HS sync byte on every
// active lane and deskews the lanes onto one cycle.
module lane_aligner
  import csi2_rx_pkg::*;
#(
  parameter int         NUM_LANE   = 4,
  parameter int         SKEW_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = HS_SYNC_BYTE
) (
  input  logic       clk_byte_fr_i,
  input  logic       reset_byte_fr_n_i,
  input  logic       hs_en_i,
  input  logic [7:0] bd0_i,
  input  logic [7:0] bd1_i,
  input  logic [7:0] bd2_i,
  input  logic [7:0] bd3_i,
  output logic [7:0] bd0_o,
  output logic [7:0] bd1_o,
  output logic [7:0] bd2_o,
  output logic [7:0] bd3_o,
  output logic       hs_sync_o,
  output logic       hs_valid_o,
  output logic       sync_err_o,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(SKEW_DEPTH + 1);
  localparam int TW = $clog2(SKEW_DEPTH);
  localparam logic [3:0] ACT =
    4'((1 << NUM_LANE) - 1);

  align_state_e   state_q;
  logic [3:0]     det, new_arr;
  logic [3:0]     arr_q, arr_d;
  logic [CW-1:0]  cnt_q, cnt;
  logic [CW-1:0]  a_q [MAX_LANE];
  logic [CW-1:0]  a_d [MAX_LANE];
  logic [TW-1:0]  sel_q [MAX_LANE];
  logic [7:0]     din [MAX_LANE];
  logic [7:0]     tap [MAX_LANE];
  logic [7:0]     bd_q [MAX_LANE];
  logic           started_q, start_now, all_arr;
  logic           sync_q, valid_q, err_q;

  assign din[0] = bd0_i;
  assign din[1] = bd1_i;
  assign din[2] = bd2_i;
  assign din[3] = bd3_i;

  for (genvar g = 0; g < MAX_LANE; g++) begin : g_lane
    if (g < NUM_LANE) begin : g_on
      lane_deskew_tap #(
        .DEPTH (SKEW_DEPTH),
        .SYNC  (SYNC_BYTE),
        .SW    (TW)
      ) u_tap (
        .clk_i  (clk_byte_fr_i),
        .rst_ni (reset_byte_fr_n_i),
        .clr_i  (!hs_en_i),
        .bd_i   (din[g]),
        .sel_i  (sel_q[g]),
        .det_o  (det[g]),
        .tap_o  (tap[g])
      );
    end else begin : g_off
      assign det[g] = 1'b0;
      assign tap[g] = '0;
    end
  end

  // Arrivals are monotonic, so the newest arrival
  // always carries the largest count: A == cnt.
  always_comb begin
    cnt       = started_q ? cnt_q : '0;
    new_arr   = det & ~arr_q & ACT;
    arr_d     = arr_q | new_arr;
    all_arr   = &(arr_d | ~ACT);
    start_now = started_q | (|new_arr);
    for (int i = 0; i < MAX_LANE; i++)
      a_d[i] = new_arr[i] ? cnt : a_q[i];
  end

  always_ff @(posedge clk_byte_fr_i or
              negedge reset_byte_fr_n_i) begin
    if (!reset_byte_fr_n_i) begin
      state_q   <= ST_IDLE;
      arr_q     <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      sync_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_LANE; i++) begin
        a_q[i]   <= '0;
        sel_q[i] <= '0;
        bd_q[i]  <= '0;
      end
    end else begin
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_LANE; i++)
        bd_q[i] <= '0;
      if (!hs_en_i) begin
        state_q   <= ST_IDLE;
        arr_q     <= '0;
        cnt_q     <= '0;
        started_q <= 1'b0;
        for (int i = 0; i < MAX_LANE; i++) begin
          a_q[i]   <= '0;
          sel_q[i] <= '0;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: state_q <= ST_HUNT;
          ST_HUNT: begin
            arr_q     <= arr_d;
            started_q <= start_now;
            cnt_q     <= start_now ? cnt + 1'b1 : '0;
            for (int i = 0; i < MAX_LANE; i++)
              a_q[i] <= a_d[i];
            if (start_now && all_arr) begin
              state_q <= ST_ALIGNED;
              sync_q  <= 1'b1;
              for (int i = 0; i < MAX_LANE; i++) begin
                sel_q[i] <= TW'(cnt - a_d[i]);
                bd_q[i]  <= ACT[i] ? SYNC_BYTE : 8'h00;
              end
            end else if (start_now &&
                         cnt == CW'(SKEW_DEPTH - 1)) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
          ST_ALIGNED: begin
            valid_q <= 1'b1;
            for (int i = 0; i < MAX_LANE; i++)
              bd_q[i] <= tap[i];
          end
          ST_ERROR: state_q <= ST_ERROR;
        endcase
      end
    end
  end

  assign bd0_o      = bd_q[0];
  assign bd1_o      = bd_q[1];
  assign bd2_o      = bd_q[2];
  assign bd3_o      = bd_q[3];
  assign hs_sync_o  = sync_q;
  assign hs_valid_o = valid_q;
  assign sync_err_o = err_q;
  assign state_o    = state_q;

endmodule
